// File: rtl/result_serializer.sv
// result_serializer: drains encrypter result words in strict index order and streams
// them MSB-first as 4-bit QSPI nibbles. Define SERIALIZER_PARITY_EN to append an XOR parity nibble.
module result_serializer #(
  parameter int NUM_ENCRYPTERS  = 4,
  parameter int ENCRYPTER_WIDTH = 32
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] encrypters_data,
  input  logic [NUM_ENCRYPTERS-1:0]                 encrypters_valid,
  output logic [NUM_ENCRYPTERS-1:0]                 encrypters_ack,
  output logic [3:0]                                qspi_data,
  output logic                                      qspi_valid,
  output logic                                      qspi_last,
  input  logic                                      qspi_ready
);

  localparam int DATA_NIBBLES = ENCRYPTER_WIDTH / 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int NIBBLES = DATA_NIBBLES + 1;
`else
  localparam int NIBBLES = DATA_NIBBLES;
`endif
  localparam int SR_WIDTH = NIBBLES * 4;
  localparam int IDX_W    = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;
  localparam int CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_ENCRYPTERS - 1);

  localparam logic [0:0] ST_WAIT  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]                 state;
  logic [IDX_W-1:0]           idx;
  logic [CNT_W-1:0]           cnt;
  logic [SR_WIDTH-1:0]        shift_reg;

  logic [ENCRYPTER_WIDTH-1:0] sel_word;
  logic                       sel_valid;
  logic [SR_WIDTH-1:0]        load_word;
  logic [SR_WIDTH-1:0]        shifted;
  logic [NUM_ENCRYPTERS-1:0]  ack_onehot;
  logic                       transfer;

`ifdef SERIALIZER_PARITY_EN
  function automatic logic [3:0] nibble_parity(input logic [ENCRYPTER_WIDTH-1:0] word);
    logic [3:0] p;
    p = 4'h0;
    for (int i = 0; i < DATA_NIBBLES; i++) begin
      p = p ^ word[i*4 +: 4];
    end
    return p;
  endfunction
`endif

  // Only the encrypter at the current index is ever looked at.
  always_comb begin
    sel_word        = encrypters_data[idx*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
    sel_valid       = encrypters_valid[idx];
    ack_onehot      = '0;
    ack_onehot[idx] = 1'b1;
`ifdef SERIALIZER_PARITY_EN
    load_word       = {sel_word, nibble_parity(sel_word)};
`else
    load_word       = sel_word;
`endif
    shifted         = shift_reg << 4;
    transfer        = qspi_valid && qspi_ready;
  end

  // qspi_data always mirrors the top nibble of the (next) shift register value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_WAIT;
      idx            <= '0;
      cnt            <= '0;
      shift_reg      <= '0;
      encrypters_ack <= '0;
      qspi_data      <= 4'h0;
      qspi_valid     <= 1'b0;
      qspi_last      <= 1'b0;
    end else begin
      encrypters_ack <= '0;
      case (state)
        ST_WAIT: begin
          if (sel_valid) begin
            shift_reg      <= load_word;
            qspi_data      <= load_word[SR_WIDTH-1 -: 4];
            qspi_valid     <= 1'b1;
            qspi_last      <= (CNT_LOAD == '0);
            cnt            <= CNT_LOAD;
            encrypters_ack <= ack_onehot;
            state          <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (transfer) begin
            if (cnt == '0) begin
              state      <= ST_WAIT;
              qspi_valid <= 1'b0;
              qspi_last  <= 1'b0;
              qspi_data  <= 4'h0;
              idx        <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
            end else begin
              shift_reg <= shifted;
              qspi_data <= shifted[SR_WIDTH-1 -: 4];
              cnt       <= cnt - CNT_W'(1);
              qspi_last <= (cnt == CNT_W'(1));
            end
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: doc/result_serializer.md
# result_serializer

Collects finished ciphertext words from the `NUM_ENCRYPTERS` encrypter instances and streams them back to the test bench as 4-bit QSPI nibbles. The Paralellizer fans input data out to encrypters in index order, so this block drains them in the same strict order: encrypter 0, then 1, through N-1, then wraps to 0. Output ordering therefore matches input ordering.

## Interface
- `NUM_ENCRYPTERS`, default 4: number of encrypter result ports; must be ≥1.
- `ENCRYPTER_WIDTH`, default 32: bits per result word; must be a multiple of 4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `encrypters_data` input `NUM_ENCRYPTERS*ENCRYPTER_WIDTH`: result words; encrypter i occupies bits `[i*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH]`.
- `encrypters_valid` input `NUM_ENCRYPTERS`: bit i high means encrypter i holds a finished word; it is held stable until acked.
- `encrypters_ack` output `NUM_ENCRYPTERS`: registered one-hot, one-cycle pulse marking that word i was captured.
- `qspi_data` output 4: current nibble, MSB-first.
- `qspi_valid` output 1: `qspi_data` is valid.
- `qspi_last` output 1: high with the final nibble of each word.
- `qspi_ready` input 1: bench accepts the nibble this cycle.

## Operation
- State machine states are WAIT and SHIFT. Reset enters WAIT with `idx` = 0.
- WAIT:
  - `encrypters_valid[idx]` high: capture the word into the shift register, load the nibble counter with `NIBBLES-1`, set `encrypters_ack[idx]` for the next cycle, and go to SHIFT.
  - `valid` bits for other indices are ignored.
- `NIBBLES` = `ENCRYPTER_WIDTH/4`. With the parity option enabled, `NIBBLES` is `ENCRYPTER_WIDTH/4 + 1`.
- SHIFT:
  - `qspi_valid` = 1 and `qspi_data` = the top nibble of the shift register.
  - A transfer occurs when `qspi_valid && qspi_ready`. On each transfer the register shifts left by 4 and the counter decrements.
  - `qspi_ready` low: `qspi_data`, `qspi_last`, the counter and the register hold.
  - Transfer with counter = 0: return to WAIT, clear `qspi_valid`, and set `idx` = (`idx`+1) mod `NUM_ENCRYPTERS`. With `NUM_ENCRYPTERS` = 1, `idx` stays 0.
- `qspi_last` = (counter == 0) while in SHIFT.
- Encrypter handshake: the encrypter deasserts `valid` no later than the cycle after it sees `ack`. The serializer does not re-sample index i until the next full wrap of `idx`.
- All outputs are registered.

## Timing
- Reset values: `encrypters_ack` = 0, `qspi_data` = 0, `qspi_valid` = 0, `qspi_last` = 0, state = WAIT, `idx` = 0, counter = 0, shift register = 0.
- Reset mid-word: the partial word is discarded and is not re-requested. The next word comes from encrypter 0.
- Latency:
  - Edge k samples `valid[idx]` high.
  - Cycle k+1: `qspi_valid` = 1 with the first nibble, and `ack[idx]` is pulsed.
  - The last nibble leaves at best on edge k+NIBBLES.
  - WAIT costs at least 1 cycle between words, so with `qspi_ready` held high throughput is `NIBBLES` nibbles per `NIBBLES+1` cycles.
- A `valid` that rises while in SHIFT for the next `idx` is sampled in the first WAIT cycle.
- `qspi_ready` is don't-care while `qspi_valid` = 0.

## Configuration
- `SERIALIZER_PARITY_EN` defined:
  - After the data nibbles, one extra nibble is emitted, equal to the XOR of all `ENCRYPTER_WIDTH/4` data nibbles.
  - `qspi_last` marks the parity nibble instead of the final data nibble.
- `SERIALIZER_PARITY_EN` undefined: exactly `ENCRYPTER_WIDTH/4` nibbles per word; no parity logic is present.

## Test plan
- Single word, defaults, `qspi_ready`=1:
  - Stimulus: `valid[0]`=1 with data `0xDEADBEEF`.
  - Response: nibbles D,E,A,D,B,E,E,F on 8 consecutive cycles; `qspi_last` only on F; `ack[0]` pulses once in the first output cycle.
- Ordering:
  - Stimulus: all four valid at once with words `0x11111111`, `0x22222222`, `0x33333333`, `0x44444444`.
  - Response: output order is 1…,2…,3…,4…; `ack` bits pulse in order 0,1,2,3, each a single cycle; `idx` wraps to 0.
- Out-of-order readiness:
  - Stimulus: `valid[2]` asserted first, `valid[0]` asserted 20 cycles later.
  - Response: no output for those 20 cycles; word 0 is emitted first, then word 1 is waited on, then word 2.
- Backpressure:
  - Stimulus: `qspi_ready` toggles 1,0,0,1,… during `0xCAFEF00D`.
  - Response: each nibble is held while ready=0; sequence is C,A,F,E,F,0,0,D with none dropped or duplicated.
- Reset mid-word:
  - Stimulus: `reset` pulsed after 3 nibbles of encrypter 1's word.
  - Response: all outputs go to 0 immediately (asynchronous), `idx` = 0, and the next emitted word comes from encrypter 0.
- Parity (`SERIALIZER_PARITY_EN` defined):
  - Stimulus: word `0x12345678`.
  - Response: nibbles 1..8 then parity `0x8`, 9 nibbles total, `qspi_last` on the parity nibble only.
